status_scoreboard: RTL and testbench
====================================

# status_scoreboard

Synthesizable, parametrised run checker for the `core`/`data_mem` system. It scores the core's `o_status`/`o_status_valid` stream against a golden status ROM and enforces a cycle budget. After a terminal status, it sweeps a word range of data memory against a golden data ROM. It sits beside the core on FPGA/emulation builds and reports pass/fail, counters and the first failure without any simulator support.

## Interface
- `STATUS_W`, 3: status code width.
- `DEPTH`, 1024: golden status entries; `SA_W = $clog2(DEPTH)`.
- `DATA_W`, 32: memory word width.
- `MEM_AW`, 11: word-index width for data memory and golden data.
- `MAX_CYCLE`, 120000: cycle budget in RUN.
- `EOF_CODE`, 6: terminal status code.
- `INV_CODE`, 5: terminal status code.
- `MAX_MEM_ERR`, 10: memory mismatches before the sweep aborts.
- `CNT_W`, 32: counter width.

Ports:
- `i_clk` in 1: clock. One clock domain; all logic on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: start a run; sampled only in IDLE or DONE.
- `i_status_len` in SA_W+1: expected status count; latched on start.
- `i_chk_lo`, `i_chk_hi` in MEM_AW each: inclusive memory sweep range; latched on start.
- `i_status` in STATUS_W, `i_status_valid` in 1: core status stream.
- `o_gs_addr` out SA_W, `i_gs_data` in STATUS_W: golden status ROM, 1-cycle read latency.
- `o_mem_addr` out MEM_AW, `i_mem_rdata` in DATA_W: data memory read, 1-cycle latency.
- `o_gd_addr` out MEM_AW, `i_gd_data` in DATA_W: golden data ROM, 1-cycle latency.
- `o_busy`, `o_done`, `o_pass` out 1 each.
- `o_fail_code` out 2: 0 none, 1 mismatch, 2 timeout, 3 extra status.
- `o_cycle_cnt`, `o_status_cnt`, `o_err_cnt` out CNT_W each.
- `o_mem_err_cnt` out 4.
- `o_first_err_idx` out CNT_W: status index or memory word index of the first error.

## Operation
- States: IDLE, RUN, DRAIN, MEMCHK, DONE.
- **IDLE/DONE + `i_start`:** clear all counters and `o_fail_code`, latch lengths and range, go to RUN.
- **RUN cycle counter:** `o_cycle_cnt` increments every RUN cycle.
- **RUN timeout:** when the counter reaches `MAX_CYCLE - 1` with no terminal event, set code 2 and go to DONE.
- **RUN status accept:** each `i_status_valid` cycle is accepted.
  - `o_gs_addr = o_status_cnt` combinationally; status_cnt increments on accept.
  - The accepted code is registered and compared next cycle against `i_gs_data`.
  - Back-to-back valids are fully pipelined.
- **Extra status:** an accept with `o_status_cnt >= len` sets code 3, increments err, and goes to DONE immediately. No golden compare is made for it.
- **Mismatch:** increments `o_err_cnt`. The first one records its index and sets code 1 if the code is still 0. The run continues.
- **Terminal status:** an accept with code EOF_CODE or INV_CODE goes to DRAIN after its compare. DRAIN lasts exactly 1 cycle, so the final store lands, then MEMCHK. Statuses arriving in DRAIN or later are ignored.
- **MEMCHK:**
  - Issue `o_mem_addr = o_gd_addr = idx`, for idx from lo to hi, one per cycle.
  - Compare on the following cycle. Each unequal word increments `o_mem_err_cnt`, records the first index if none is recorded, and sets code 1 if code is 0.
  - On reaching `MAX_MEM_ERR`, stop issuing, discard the in-flight compare, and go to DONE.
  - If lo > hi, skip to DONE.
- **DONE:** `o_done=1`; `o_pass = (err==0 && mem_err==0 && code==0)`. Outputs are held until the next start or reset.
- `o_busy` = RUN | DRAIN | MEMCHK.
- `i_start` outside IDLE/DONE is ignored.
- Reset at any point forces IDLE and zeros everything, including in-flight compares.

## Timing
- **Reset values:** state IDLE. All outputs 0, including `o_pass`, `o_done`, `o_busy`, all counters, code, `o_first_err_idx`, and all addresses.
- **Start latency:** `i_start` at edge k puts the block in RUN at k+1. The first cycle count occurs at k+1.
- **Status compare latency:** 1 cycle after accept. Err/fail updates are visible 2 edges after the valid cycle.
- **Terminal to MEMCHK:** 3 edges (compare, DRAIN, MEMCHK entry).
- **Sweep duration:** (hi−lo+1)+1 cycles, then DONE.
- **Counters:** saturate at all-ones; no wrap.
- **Timeout vs. terminal:** a timeout coinciding with a terminal accept is resolved in favour of terminal.

## Test plan
- **Clean run:** len=4, golden {0,1,2,6}, stream {0,1,2,6} back-to-back, range 1024..1027 all equal → DONE, pass=1, status_cnt=4, err=0.
- **Mismatch:** golden {0,3,6}, stream {0,1,6} → err=1, first_err_idx=1, code=1, pass=0, memory sweep still runs.
- **Timeout:** MAX_CYCLE=50, no valid → DONE at RUN cycle 50, code=2, status_cnt=0.
- **Extra status:** len=2, golden {0,1}, stream {0,1,2} → code=3, err=1, DONE without MEMCHK.
- **Memory abort:** 12 mismatched words in the range, MAX_MEM_ERR=10 → mem_err=10, first_err_idx=lo, code=1.
- **Reset mid-run:** assert `i_rst` mid-MEMCHK → next cycle all outputs 0 and IDLE. A new start then passes the clean run.

Source files
------------

// File: rtl/status_scoreboard.sv
// status_scoreboard: scores a core's status stream against a golden status ROM
// and enforces a cycle budget. After a terminal status it sweeps a word range of
// data memory against a golden data ROM. Reports pass/fail, counters and the
// index of the first failure.
module status_scoreboard #(
  parameter int STATUS_W    = 3,
  parameter int DEPTH       = 1024,
  parameter int DATA_W      = 32,
  parameter int MEM_AW      = 11,
  parameter int MAX_CYCLE   = 120000,
  parameter int EOF_CODE    = 6,
  parameter int INV_CODE    = 5,
  parameter int MAX_MEM_ERR = 10,
  parameter int CNT_W       = 32,
  localparam int SA_W       = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [SA_W:0]       i_status_len,
  input  logic [MEM_AW-1:0]   i_chk_lo,
  input  logic [MEM_AW-1:0]   i_chk_hi,
  input  logic [STATUS_W-1:0] i_status,
  input  logic                i_status_valid,
  output logic [SA_W-1:0]     o_gs_addr,
  input  logic [STATUS_W-1:0] i_gs_data,
  output logic [MEM_AW-1:0]   o_mem_addr,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [MEM_AW-1:0]   o_gd_addr,
  input  logic [DATA_W-1:0]   i_gd_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [1:0]          o_fail_code,
  output logic [CNT_W-1:0]    o_cycle_cnt,
  output logic [CNT_W-1:0]    o_status_cnt,
  output logic [CNT_W-1:0]    o_err_cnt,
  output logic [3:0]          o_mem_err_cnt,
  output logic [CNT_W-1:0]    o_first_err_idx
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_MEMCHK, S_DONE} state_t;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_MIS   = 2'd1;
  localparam logic [1:0] FC_TMO   = 2'd2;
  localparam logic [1:0] FC_EXTRA = 2'd3;

  state_t              state_q;
  logic                busy_q, done_q;
  logic [1:0]          code_q;
  logic [CNT_W-1:0]    cycle_q, scnt_q, err_q, fidx_q;
  logic [3:0]          merr_q;
  logic                frec_q;        // first error index already captured
  logic [SA_W:0]       len_q;
  logic [MEM_AW-1:0]   lo_q, hi_q, idx_q;
  logic                issue_q;       // sweep still issuing addresses
  logic                term_pend_q;   // terminal accepted, its compare is in flight
  logic                cmp_vld_q;
  logic [STATUS_W-1:0] cmp_code_q;
  logic [CNT_W-1:0]    cmp_idx_q;
  logic                mvld_q;
  logic [MEM_AW-1:0]   midx_q;

  logic             acc, extra, is_term, tmo, st_mis, m_mis, m_abort;
  logic [CNT_W-1:0] err_nxt;
  logic [3:0]       merr_nxt;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Status-side decode: accept, overflow past expected length, terminal, budget
  always_comb begin
    acc      = (state_q == S_RUN) && i_status_valid && !term_pend_q;
    extra    = acc && (scnt_q >= CNT_W'(len_q));
    is_term  = (i_status == STATUS_W'(EOF_CODE)) || (i_status == STATUS_W'(INV_CODE));
    // a terminal accept on the last budget cycle wins over the timeout
    tmo      = (state_q == S_RUN) && !term_pend_q && !(acc && is_term) &&
               (cycle_q == CNT_W'(MAX_CYCLE - 1));
    st_mis   = cmp_vld_q && (cmp_code_q != i_gs_data);
    // a pending mismatch and an extra status can both land on the same edge
    err_nxt  = err_q;
    if (st_mis) err_nxt = inc_sat(err_nxt);
    if (extra)  err_nxt = inc_sat(err_nxt);
    m_mis    = mvld_q && (i_mem_rdata != i_gd_data);
    merr_nxt = (m_mis && !(&merr_q)) ? merr_q + 4'd1 : merr_q;
    m_abort  = m_mis && (32'(merr_nxt) == 32'(MAX_MEM_ERR));
  end

  // Run FSM: start, status scoring, drain, memory sweep, done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      code_q      <= FC_NONE;
      cycle_q     <= '0;
      scnt_q      <= '0;
      err_q       <= '0;
      fidx_q      <= '0;
      merr_q      <= '0;
      frec_q      <= 1'b0;
      len_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      idx_q       <= '0;
      issue_q     <= 1'b0;
      term_pend_q <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_code_q  <= '0;
      cmp_idx_q   <= '0;
      mvld_q      <= 1'b0;
      midx_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            code_q      <= FC_NONE;
            cycle_q     <= '0;
            scnt_q      <= '0;
            err_q       <= '0;
            fidx_q      <= '0;
            merr_q      <= '0;
            frec_q      <= 1'b0;
            len_q       <= i_status_len;
            lo_q        <= i_chk_lo;
            hi_q        <= i_chk_hi;
            issue_q     <= 1'b0;
            term_pend_q <= 1'b0;
            cmp_vld_q   <= 1'b0;
            mvld_q      <= 1'b0;
          end
        end
        S_RUN: begin
          cycle_q    <= inc_sat(cycle_q);
          err_q      <= err_nxt;
          if (acc) scnt_q <= inc_sat(scnt_q);
          cmp_vld_q  <= acc && !extra && !tmo;
          cmp_code_q <= i_status;
          cmp_idx_q  <= scnt_q;
          if (st_mis && !frec_q) begin
            fidx_q <= cmp_idx_q;
            frec_q <= 1'b1;
            if (code_q == FC_NONE) code_q <= FC_MIS;
          end
          if (extra) begin
            code_q  <= FC_EXTRA;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (acc && is_term) begin
            term_pend_q <= 1'b1;
          end else if (term_pend_q) begin
            // the terminal compare lands on this edge
            term_pend_q <= 1'b0;
            state_q     <= S_DRAIN;
          end else if (tmo) begin
            code_q  <= FC_TMO;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DRAIN: begin
          // one idle cycle lets the core's final store reach memory
          idx_q   <= lo_q;
          issue_q <= 1'b1;
          mvld_q  <= 1'b0;
          if (lo_q > hi_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_MEMCHK;
          end
        end
        S_MEMCHK: begin
          if (m_mis) begin
            merr_q <= merr_nxt;
            if (!frec_q) begin
              fidx_q <= CNT_W'(midx_q);
              frec_q <= 1'b1;
            end
            if (code_q == FC_NONE) code_q <= FC_MIS;
          end
          if (m_abort || !issue_q) begin
            // abort drops the in-flight word; otherwise the last compare just landed
            mvld_q  <= 1'b0;
            issue_q <= 1'b0;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            mvld_q <= 1'b1;
            midx_q <= idx_q;
            if (idx_q == hi_q) issue_q <= 1'b0;
            else               idx_q   <= idx_q + MEM_AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_gs_addr       = scnt_q[SA_W-1:0];
  assign o_mem_addr      = idx_q;
  assign o_gd_addr       = idx_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_pass          = done_q && (err_q == '0) && (merr_q == '0) && (code_q == FC_NONE);
  assign o_fail_code     = code_q;
  assign o_cycle_cnt     = cycle_q;
  assign o_status_cnt    = scnt_q;
  assign o_err_cnt       = err_q;
  assign o_mem_err_cnt   = merr_q;
  assign o_first_err_idx = fidx_q;

endmodule

// File: tb/tb_status_scoreboard.sv
// Directed bench for status_scoreboard: golden ROMs and data memory are modelled
// as 1-cycle-latency arrays; each scenario task checks its own expectations.
module tb_status_scoreboard;

  localparam int SA_W = 10;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [SA_W:0] i_status_len = '0;
  logic [10:0]   i_chk_lo = '0, i_chk_hi = '0;
  logic [2:0]    i_status = '0;
  logic          i_status_valid = 1'b0;
  logic [SA_W-1:0] o_gs_addr;
  logic [2:0]    i_gs_data = '0;
  logic [10:0]   o_mem_addr, o_gd_addr;
  logic [31:0]   i_mem_rdata = '0, i_gd_data = '0;
  logic          o_busy, o_done, o_pass;
  logic [1:0]    o_fail_code;
  logic [31:0]   o_cycle_cnt, o_status_cnt, o_err_cnt, o_first_err_idx;
  logic [3:0]    o_mem_err_cnt;

  logic [2:0]  gold  [0:1023];
  logic [31:0] mem   [0:2047];
  logic [31:0] gd    [0:2047];
  logic [2:0]  stream[0:7];

  int pass_n = 0, tot_n = 0;
  bit swept;
  logic [10:0] mon_hi = '0;

  status_scoreboard #(.MAX_CYCLE(50)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_status_len(i_status_len),
    .i_chk_lo(i_chk_lo), .i_chk_hi(i_chk_hi), .i_status(i_status),
    .i_status_valid(i_status_valid), .o_gs_addr(o_gs_addr), .i_gs_data(i_gs_data),
    .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata), .o_gd_addr(o_gd_addr),
    .i_gd_data(i_gd_data), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_fail_code(o_fail_code), .o_cycle_cnt(o_cycle_cnt), .o_status_cnt(o_status_cnt),
    .o_err_cnt(o_err_cnt), .o_mem_err_cnt(o_mem_err_cnt), .o_first_err_idx(o_first_err_idx)
  );

  always #5 i_clk = ~i_clk;

  // 1-cycle read latency ROM / memory models
  always @(posedge i_clk) begin
    i_gs_data   <= gold[o_gs_addr];
    i_mem_rdata <= mem[o_mem_addr];
    i_gd_data   <= gd[o_gd_addr];
  end

  always @(negedge i_clk) if (o_busy && o_mem_addr == mon_hi) swept = 1'b1;

  task automatic start_run(input int len, input int lo, input int hi);
    @(negedge i_clk);
    i_status_len = (SA_W+1)'(len);
    i_chk_lo = 11'(lo);
    i_chk_hi = 11'(hi);
    mon_hi = 11'(hi);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    swept = 1'b0;
  endtask

  task automatic send_stream(input int n);
    for (int i = 0; i < n; i++) begin
      i_status_valid = 1'b1;
      i_status = stream[i];
      @(negedge i_clk);
    end
    i_status_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (o_done) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    tot_n++;
    if (ok !== 1'b1) $display("FAIL %s_done_wait: done=%0b want 1 within 400 cycles", nm, o_done);
    else pass_n++;
  endtask

  task automatic test_reset;
    logic [168:0] v;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    v = {o_busy, o_done, o_pass, o_fail_code, o_cycle_cnt, o_status_cnt, o_err_cnt,
         o_mem_err_cnt, o_first_err_idx, o_gs_addr, o_mem_addr, o_gd_addr};
    tot_n++;
    if (v !== '0) $display("FAIL reset_outputs: got %h want 0", v); else pass_n++;
  endtask

  task automatic test_clean(input string nm);
    gold[0] = 3'd0; gold[1] = 3'd1; gold[2] = 3'd2; gold[3] = 3'd6;
    stream[0] = 3'd0; stream[1] = 3'd1; stream[2] = 3'd2; stream[3] = 3'd6;
    start_run(4, 1024, 1027);
    tot_n++;
    if ({o_busy, o_cycle_cnt} !== {1'b1, 32'd0})
      $display("FAIL %s_start: busy=%0b cyc=%0d want busy=1 cyc=0", nm, o_busy, o_cycle_cnt);
    else pass_n++;
    send_stream(4);
    wait_done(nm);
    tot_n++;
    if ({o_pass, o_fail_code, o_status_cnt, o_err_cnt, o_mem_err_cnt} !== {1'b1, 2'd0, 32'd4, 32'd0, 4'd0})
      $display("FAIL %s_result: pass=%0b code=%0d scnt=%0d err=%0d merr=%0d want 1/0/4/0/0",
               nm, o_pass, o_fail_code, o_status_cnt, o_err_cnt, o_mem_err_cnt);
    else pass_n++;
    tot_n++;
    if (swept !== 1'b1) $display("FAIL %s_sweep: swept=%0b want 1", nm, swept); else pass_n++;
  endtask

  task automatic test_done_hold;
    repeat (5) @(negedge i_clk);
    tot_n++;
    if ({o_done, o_pass, o_busy} !== 3'b110)
      $display("FAIL done_hold: done/pass/busy=%b want 110", {o_done, o_pass, o_busy});
    else pass_n++;
  endtask

  task automatic test_mismatch;
    gold[0] = 3'd0; gold[1] = 3'd3; gold[2] = 3'd6;
    stream[0] = 3'd0; stream[1] = 3'd1; stream[2] = 3'd6;
    start_run(3, 0, 7);
    send_stream(3);
    wait_done("mismatch");
    tot_n++;
    if ({o_err_cnt, o_first_err_idx, o_fail_code, o_pass} !== {32'd1, 32'd1, 2'd1, 1'b0})
      $display("FAIL mismatch_result: err=%0d fidx=%0d code=%0d pass=%0b want 1/1/1/0",
               o_err_cnt, o_first_err_idx, o_fail_code, o_pass);
    else pass_n++;
    tot_n++;
    if ({swept, o_mem_err_cnt, o_status_cnt} !== {1'b1, 4'd0, 32'd3})
      $display("FAIL mismatch_sweep: swept=%0b merr=%0d scnt=%0d want 1/0/3", swept, o_mem_err_cnt, o_status_cnt);
    else pass_n++;
  endtask

  task automatic test_timeout;
    start_run(4, 0, 3);
    repeat (49) @(negedge i_clk);
    tot_n++;
    if ({o_busy, o_done, o_cycle_cnt} !== {1'b1, 1'b0, 32'd49})
      $display("FAIL timeout_pre: busy=%0b done=%0b cyc=%0d want 1/0/49", o_busy, o_done, o_cycle_cnt);
    else pass_n++;
    @(negedge i_clk);
    tot_n++;
    if ({o_done, o_fail_code, o_cycle_cnt, o_status_cnt, o_pass} !== {1'b1, 2'd2, 32'd50, 32'd0, 1'b0})
      $display("FAIL timeout_result: done=%0b code=%0d cyc=%0d scnt=%0d pass=%0b want 1/2/50/0/0",
               o_done, o_fail_code, o_cycle_cnt, o_status_cnt, o_pass);
    else pass_n++;
  endtask

  task automatic test_term_at_limit_empty_range;
    gold[0] = 3'd6;
    start_run(1, 5, 4);
    repeat (49) @(negedge i_clk);
    stream[0] = 3'd6;
    send_stream(1);
    wait_done("term_limit");
    tot_n++;
    if ({o_pass, o_fail_code, o_status_cnt, o_mem_err_cnt} !== {1'b1, 2'd0, 32'd1, 4'd0})
      $display("FAIL term_limit_result: pass=%0b code=%0d scnt=%0d merr=%0d want 1/0/1/0",
               o_pass, o_fail_code, o_status_cnt, o_mem_err_cnt);
    else pass_n++;
  endtask

  task automatic test_extra;
    gold[0] = 3'd0; gold[1] = 3'd1;
    stream[0] = 3'd0; stream[1] = 3'd1; stream[2] = 3'd2;
    start_run(2, 20, 30);
    send_stream(3);
    tot_n++;
    if ({o_done, o_busy, o_fail_code, o_err_cnt, o_pass} !== {1'b1, 1'b0, 2'd3, 32'd1, 1'b0})
      $display("FAIL extra_result: done=%0b busy=%0b code=%0d err=%0d pass=%0b want 1/0/3/1/0",
               o_done, o_busy, o_fail_code, o_err_cnt, o_pass);
    else pass_n++;
  endtask

  task automatic test_mem_abort;
    for (int i = 100; i < 112; i++) mem[i] = mem[i] ^ 32'h1;
    gold[0] = 3'd6; stream[0] = 3'd6;
    start_run(1, 100, 119);
    send_stream(1);
    wait_done("mem_abort");
    tot_n++;
    if ({o_mem_err_cnt, o_first_err_idx, o_fail_code, o_err_cnt, o_pass} !== {4'd10, 32'd100, 2'd1, 32'd0, 1'b0})
      $display("FAIL mem_abort_result: merr=%0d fidx=%0d code=%0d err=%0d pass=%0b want 10/100/1/0/0",
               o_mem_err_cnt, o_first_err_idx, o_fail_code, o_err_cnt, o_pass);
    else pass_n++;
    for (int i = 100; i < 112; i++) mem[i] = gd[i];
  endtask

  task automatic test_reset_mid_memchk;
    bit ok = 1'b0;
    logic [168:0] v;
    gold[0] = 3'd6; stream[0] = 3'd6;
    start_run(1, 0, 200);
    send_stream(1);
    for (int i = 0; i < 400; i++) begin
      if (o_busy && o_mem_addr == 11'd50) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    tot_n++;
    if (ok !== 1'b1) $display("FAIL rst_mid_reach: addr=%0d want 50 within 400 cycles", o_mem_addr);
    else pass_n++;
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    v = {o_busy, o_done, o_pass, o_fail_code, o_cycle_cnt, o_status_cnt, o_err_cnt,
         o_mem_err_cnt, o_first_err_idx, o_gs_addr, o_mem_addr, o_gd_addr};
    tot_n++;
    if (v !== '0) $display("FAIL rst_mid_outputs: got %h want 0", v); else pass_n++;
    test_clean("after_rst");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) gold[i] = 3'd0;
    for (int i = 0; i < 2048; i++) begin
      gd[i]  = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
      mem[i] = gd[i];
    end
    for (int i = 0; i < 8; i++) stream[i] = 3'd0;
    test_reset();
    test_clean("clean");
    test_done_hold();
    test_mismatch();
    test_timeout();
    test_term_at_limit_empty_range();
    test_extra();
    test_mem_abort();
    test_reset_mid_memchk();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
